// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: shifts DATA_W-bit words out MSB first
// on SCK/MOSI/CS with a start/busy/done handshake toward the producer.
module spi_master_tx #(
    parameter int CLK_DIV = 50,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_cs
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tail_q, tail_d;
    logic              half_end;

    assign half_end = (div_q == DIV_LAST);

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tail_d  = tail_q;

        if (state_q != IDLE) begin
            div_d = half_end ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = SETUP;
                    shreg_d = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    tail_d  = 1'b0;
                end
            end
            SETUP: begin
                if (half_end) begin
                    sck_d   = 1'b1;
                    bit_d   = BIT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            // last bit stays on MOSI until CS rises
                            state_d = HOLD;
                        end else begin
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                            mosi_d  = shreg_q[DATA_W-2];
                        end
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            HOLD: begin
                // CS trails the final SCK fall by a full bit cell
                if (half_end) begin
                    if (!tail_q) begin
                        tail_d = 1'b1;
                    end else begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (half_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tail_q  <= tail_d;
        end
    end

    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign spi_clk  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs   = cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: frame-level reference model compared every
// cycle, plus frame monitors checked against hand-computed values.
module tb_spi_master_tx;

    localparam int D = 4;
    localparam int W = 16;
    localparam int CS_LOW = (2 * W + 2) * D;
    localparam int BUSY_LEN = (2 * W + 3) * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_start = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_busy, tx_done, spi_clk, spi_mosi, spi_cs;

    always #5 clk = ~clk;

    spi_master_tx #(.CLK_DIV(D), .DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_cs   (spi_cs)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // reference model: frame position n counted in clocks since acceptance
    bit         started = 1'b0;
    bit         m_active = 1'b0;
    int         m_n = 0;
    logic [W-1:0] m_data = '0;

    initial begin
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (rst) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (m_n + 1 < BUSY_LEN) m_n++;
                else m_active = 1'b0;
            end else if (tx_start) begin
                m_active = 1'b1;
                m_n = 0;
                m_data = tx_data;
            end
        end
    end

    logic [4:0] ce, ca;
    int         cidx;
    logic       ecs, esck, emosi;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (!m_active) begin
                    ce = 5'b10000;
                end else begin
                    ecs = (m_n >= CS_LOW);
                    esck = (m_n >= D) && (m_n < (2 * W + 1) * D)
                           && (((m_n / D) % 2) == 1);
                    cidx = m_n / (2 * D);
                    if (cidx > W - 1) cidx = W - 1;
                    emosi = ecs ? 1'b0 : m_data[W-1-cidx];
                    ce = {ecs, esck, emosi, 1'b1, (m_n == CS_LOW) ? 1'b1 : 1'b0};
                end
                ca = {spi_cs, spi_clk, spi_mosi, tx_busy, tx_done};
                checks++;
                if (ca !== ce) begin
                    failures++;
                    $display("FAIL cycle {cs,sck,mosi,busy,done} actual=%b expected=%b t=%0t",
                             ca, ce, $time);
                end
            end
        end
    end

    // frame monitor
    int           f_low[$];
    int           f_rise[$];
    logic [W-1:0] f_word[$];
    bit           f_done[$];
    int           f_gap[$];
    bit           prev_cs = 1'b1;
    bit           prev_sck = 1'b0;
    bit           have_frame = 1'b0;
    int           cur_low = 0;
    int           cur_rise = 0;
    logic [W-1:0] cur_word = '0;
    int           high_cnt = 0;
    int           done_total = 0;
    bit           d2i_run = 1'b0;
    int           d2i_cnt = 0;
    int           last_d2i = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (tx_done) done_total++;
                if (!spi_cs) begin
                    if (prev_cs) begin
                        cur_low = 0;
                        cur_rise = 0;
                        cur_word = '0;
                        if (have_frame) f_gap.push_back(high_cnt);
                    end
                    cur_low++;
                    if (spi_clk && !prev_sck) begin
                        cur_rise++;
                        cur_word = {cur_word[W-2:0], spi_mosi};
                    end
                end else begin
                    if (!prev_cs) begin
                        f_low.push_back(cur_low);
                        f_rise.push_back(cur_rise);
                        f_word.push_back(cur_word);
                        f_done.push_back(tx_done);
                        have_frame = 1'b1;
                        high_cnt = 0;
                    end
                    high_cnt++;
                end
                if (tx_done) begin
                    d2i_run = 1'b1;
                    d2i_cnt = 0;
                end else if (d2i_run) begin
                    d2i_cnt++;
                    if (!tx_busy) begin
                        d2i_run = 1'b0;
                        last_d2i = d2i_cnt;
                    end
                end
                prev_cs = spi_cs;
                prev_sck = spi_clk;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (tx_busy && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle_timeout", tx_busy, 0);
    endtask

    task automatic send(input logic [W-1:0] d);
        wait_idle(400);
        tx_data = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    int nf, d0, k;
    logic [W-1:0] rw;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {spi_cs, spi_clk, spi_mosi, tx_busy, tx_done}, 5'b10000);
        rst = 1'b0;
        tick();

        // single frame 0xA5C3
        nf = f_word.size();
        send(16'hA5C3);
        wait_idle(400);
        tick();
        check("a5c3_frames", f_word.size(), nf + 1);
        check("a5c3_cs_low", f_low[nf], 136);
        check("a5c3_rises", f_rise[nf], 16);
        check("a5c3_word", f_word[nf], 16'hA5C3);
        check("a5c3_done_at_cs_rise", f_done[nf], 1);
        check("a5c3_done_to_idle", last_d2i, 4);
        check("a5c3_done_count", done_total, 1);

        // back-to-back 0x0000 then 0xFFFF, start held through busy
        nf = f_word.size();
        d0 = done_total;
        wait_idle(400);
        tx_data = 16'h0000;
        tx_start = 1'b1;
        tick();
        tx_data = 16'hFFFF;
        k = 0;
        while (tx_busy && k < 400) begin
            tick();
            k++;
        end
        check("b2b_busy_drop", tx_busy, 0);
        tick();
        tx_start = 1'b0;
        wait_idle(400);
        tick();
        check("b2b_frames", f_word.size(), nf + 2);
        check("b2b_word0", f_word[nf], 16'h0000);
        check("b2b_word1", f_word[nf+1], 16'hFFFF);
        check("b2b_cs_low1", f_low[nf+1], 136);
        check("b2b_cs_gap", f_gap[nf], D + 1);
        check("b2b_done_count", done_total, d0 + 2);

        // start and data change mid-frame are ignored
        nf = f_word.size();
        d0 = done_total;
        send(16'h8001);
        repeat (40) tick();
        tx_data = 16'h1234;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        wait_idle(400);
        repeat (30) tick();
        check("ignore_frames", f_word.size(), nf + 1);
        check("ignore_word", f_word[nf], 16'h8001);
        check("ignore_done_count", done_total, d0 + 1);
        check("ignore_idle", tx_busy, 0);

        // rst and tx_start together: rst wins
        nf = f_word.size();
        tx_data = 16'hBEEF;
        tx_start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_start = 1'b0;
        check("rst_start_busy", tx_busy, 0);
        repeat (5) tick();
        check("rst_start_no_frame", {spi_cs, tx_busy}, 2'b10);

        // reset after the 7th rising edge
        nf = f_word.size();
        d0 = done_total;
        send(16'h5A5A);
        k = 0;
        while (cur_rise != 7 && k < 400) begin
            tick();
            k++;
        end
        check("abort_reach_7", cur_rise, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {spi_cs, spi_clk, tx_busy, tx_done}, 4'b1000);
        check("abort_rises", f_rise[nf], 7);
        check("abort_no_done", done_total, d0);
        send(16'h00FF);
        wait_idle(400);
        tick();
        check("after_abort_word", f_word[nf+1], 16'h00FF);
        check("after_abort_rises", f_rise[nf+1], 16);

        // randomized frames with ignored mid-frame requests
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 12)) tick();
            nf = f_word.size();
            rw = W'($urandom);
            send(rw);
            for (int j = 0; j < 3; j++) begin
                repeat ($urandom_range(5, 40)) tick();
                tx_data = W'($urandom);
                tx_start = $urandom_range(0, 1) == 1;
                tick();
                tx_start = 1'b0;
            end
            wait_idle(400);
            tick();
            check("rand_word", f_word[nf], rw);
        end

        repeat (10) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
